pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline register that replaces fixed, hand-listed inter-stage latches such as IF/ID, ID/EX, EX/MEM and MEM/WB with one generic stage. It carries an opaque DW-bit payload between two pipeline stages using a valid/ready handshake, and contains a two-entry skid buffer so that in_ready is driven straight from a flop. It also supports synchronous flush with bubble (NOP) insertion and a saturating stall counter for performance monitoring.

## Interface
Parameters:
- DW, 64, payload width in bits; legal range 1..1024.
- NOP_VAL, '0 (DW bits), payload driven on out_data whenever out_valid=0; it encodes the stage's bubble, for example SLL/RTYPE control zeros.
- CW, 16, width of the stall counter.

Ports (one clock; reset is synchronous and active-high):
- CLK  input  1  clock; all state updates on its rising edge.
- RST  input  1  synchronous active-high reset.
- in_valid  input  1  upstream presents a beat.
- in_ready  output  1  stage can accept a beat; registered.
- in_data  input  DW  upstream payload.
- out_valid  output  1  stage presents a beat downstream.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DW  payload; equals NOP_VAL when out_valid=0.
- flush  input  1  discard every held beat and this cycle's input beat.
- stall_cnt  output  CW  saturating count of cycles with out_valid=1 and out_ready=0.
- clr_cnt  input  1  synchronously zero stall_cnt.

## Operation
- Accept events: acc_in = in_valid & in_ready; acc_out = out_valid & out_ready.
- The stage holds two registers, main (drives out_data) and skid, plus a state variable.
- States:
  - EMPTY: 0 beats held.
  - HOLD: main valid.
  - FULL: main and skid both valid.
- Output decode: in_ready = (state != FULL); out_valid = (state != EMPTY). Both come directly from state flops.
- Transitions from EMPTY:
  - acc_in: main <= in_data, go to HOLD.
  - otherwise: stay.
- Transitions from HOLD:
  - acc_in & acc_out: main <= in_data, stay in HOLD.
  - acc_in & !acc_out: skid <= in_data, go to FULL.
  - !acc_in & acc_out: go to EMPTY.
  - otherwise: stay; main unchanged.
- Transitions from FULL:
  - acc_out: main <= skid, go to HOLD.
  - otherwise: stay.
  - No input beat is accepted in FULL.
- Ordering: beats leave in strict acceptance order; no beat is dropped or duplicated except by flush or RST.
- Flush (priority below RST, above all else): next state is EMPTY, and main and skid are loaded with NOP_VAL. An acc_in or acc_out in the same cycle is void:
  - the input beat is discarded;
  - upstream is still told it was taken (in_ready was high), so upstream must drop it too.
- stall_cnt:
  - increments when out_valid & !out_ready & !flush;
  - saturates at 2^CW-1 with no wrap;
  - clr_cnt has priority over the increment.
- RST: state is EMPTY, main and skid are NOP_VAL, and stall_cnt is 0.

## Timing
- Reset values:
  - in_ready = 1
  - out_valid = 0
  - out_data = NOP_VAL
  - stall_cnt = 0
- Latency: a beat accepted at edge N is presented at edge N+1 when the stage was EMPTY, or in HOLD with acc_out.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Backpressure: after out_ready drops, the stage absorbs at most one further input beat (the skid) before in_ready falls, one cycle later.
- Recovery: after out_ready returns high, in_ready rises one cycle later.
- Simultaneous flush and RST: RST wins; the outcome is identical.
- Flush while FULL: both beats are lost. At the next cycle in_ready=1 and out_valid=0.
- Data stability: out_data is stable while out_valid=1 and out_ready=0, and updates only on acc_out, on acc_in from EMPTY, or on flush.
- No combinational path from in_* or out_ready to any output.

## Structure
- Add to cpu_types_pkg:
  - typedef enum logic [1:0] {PS_EMPTY, PS_HOLD, PS_FULL} pipe_state_t;
  - per-stage payload packed structs (e.g. id_ex_t) whose $bits sets DW at instantiation;
  - NOP constants per stage (e.g. ID_EX_NOP) for NOP_VAL.
- One sub-module: sat_counter (parameter CW; inputs inc and clr; output count). It is reused elsewhere for performance counters.

## Test plan
- RST with in_valid=1, in_data=0xAA -> out_valid=0, out_data=NOP_VAL, in_ready=1, stall_cnt=0 during and one cycle after RST.
- Stream 1,2,3,4 with out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, starting one cycle after the first accept; in_ready stays 1 throughout.
- Stream 1,2,3 with out_ready=0 from cycle 1 -> beat 1 held on out, beat 2 in skid, in_ready=0, beat 3 held upstream, stall_cnt increments each cycle; raise out_ready -> out 1,2,3 in order with none lost.
- Flush in FULL with in_valid=1 -> next cycle out_valid=0, out_data=NOP_VAL, in_ready=1; the beats held at the flush never appear on the output.
- CW=2 with out_ready=0 for 6 cycles -> stall_cnt reads 1,2,3,3,3; clr_cnt alongside a stall -> 0.
- Random valid/ready for 10k cycles against a scoreboard queue -> order preserved, and out_data stable whenever out_valid=1 and out_ready=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: pipeline stage state encoding, inter-stage payloads and
// their bubble (NOP) values.
package cpu_types_pkg;

  // Occupancy of an elastic pipeline stage
  typedef enum logic [1:0] {
    PS_EMPTY,
    PS_HOLD,
    PS_FULL
  } pipe_state_t;

  // Decode -> execute payload
  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } id_ex_t;

  // Execute -> memory payload
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } ex_mem_t;

  // Bubbles: all control zero, i.e. an SLL r0,r0,0 that writes nothing
  localparam id_ex_t  ID_EX_NOP  = '0;
  localparam ex_mem_t EX_MEM_NOP = '0;

  // Width helper so instantiations read DW(id_ex_t) style sizes uniformly
  function automatic int unsigned id_ex_width();
    return $bits(id_ex_t);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for performance monitoring; clear beats increment.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_reg;

  // Count up until all ones, then hold; reset and clear return to zero
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {CW{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic elastic pipeline register with a two-entry skid buffer, flush with
// bubble insertion and a saturating stall counter.
module pipe_stage_reg
  import cpu_types_pkg::*;
#(
  parameter int             DW      = 64,
  parameter logic [DW-1:0]  NOP_VAL = '0,
  parameter int             CW      = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  input  logic          flush,
  output logic [CW-1:0] stall_cnt,
  input  logic          clr_cnt
);

  pipe_state_t   state_reg;
  logic [DW-1:0] main_reg;
  logic [DW-1:0] skid_reg;
  logic          acc_in;
  logic          acc_out;

  // Handshake flags are pure state decodes, so nothing combinational reaches
  // an output from the inputs
  assign in_ready  = (state_reg != PS_FULL);
  assign out_valid = (state_reg != PS_EMPTY);
  assign acc_in    = in_valid & in_ready;
  assign acc_out   = out_valid & out_ready;

  // main is kept at NOP_VAL whenever the stage is empty, so it drives
  // out_data directly
  assign out_data = main_reg;

  // Occupancy FSM moving beats between input, skid and main
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      state_reg <= PS_EMPTY;
      main_reg  <= NOP_VAL;
      skid_reg  <= NOP_VAL;
    end else begin
      case (state_reg)
        PS_EMPTY: begin
          if (acc_in) begin
            main_reg  <= in_data;
            state_reg <= PS_HOLD;
          end
        end
        PS_HOLD: begin
          if (acc_in && acc_out) begin
            main_reg <= in_data;
          end else if (acc_in) begin
            skid_reg  <= in_data;
            state_reg <= PS_FULL;
          end else if (acc_out) begin
            main_reg  <= NOP_VAL;
            state_reg <= PS_EMPTY;
          end
        end
        PS_FULL: begin
          if (acc_out) begin
            main_reg  <= skid_reg;
            state_reg <= PS_HOLD;
          end
        end
        default: begin
          state_reg <= PS_EMPTY;
          main_reg  <= NOP_VAL;
          skid_reg  <= NOP_VAL;
        end
      endcase
    end
  end

  sat_counter #(
    .CW (CW)
  ) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (out_valid & ~out_ready & ~flush),
    .clr   (clr_cnt),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus a long random run, all
// checked against a queue-based model of a two-beat elastic buffer.
module tb_pipe_stage_reg;

  localparam int            DW      = 16;
  localparam int            CW      = 2;
  localparam logic [DW-1:0] NOP     = 16'h5A5A;
  localparam int            CNT_MAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          flush;
  logic [CW-1:0] stall_cnt;
  logic          clr_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: the stage is a FIFO of capacity two; counter is plain arithmetic
  logic [DW-1:0] mq[$];
  int            mcnt;
  logic [DW-1:0] rx[$];

  pipe_stage_reg #(
    .DW      (DW),
    .NOP_VAL (NOP),
    .CW      (CW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .stall_cnt (stall_cnt),
    .clr_cnt   (clr_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: predict from pre-edge inputs, advance model, compare after edge
  task automatic step();
    bit            a_in;
    bit            a_out;
    bit            hold_chk;
    logic [DW-1:0] hold_val;
    a_in     = in_valid && (mq.size() < 2);
    a_out    = out_ready && (mq.size() > 0);
    hold_chk = (mq.size() > 0) && !out_ready && !flush && !RST;
    hold_val = out_data;
    if (a_out && !flush && !RST) rx.push_back(out_data);
    @(posedge CLK);
    if (RST) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (clr_cnt) mcnt = 0;
      else if ((mq.size() > 0) && !out_ready && !flush && (mcnt < CNT_MAX)) mcnt++;
      if (flush) begin
        mq.delete();
      end else begin
        if (a_out) void'(mq.pop_front());
        if (a_in) mq.push_back(in_data);
      end
    end
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
    check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    check("out_data", {16'd0, out_data}, {16'd0, (mq.size() > 0) ? mq[0] : NOP});
    check("stall_cnt", {30'd0, stall_cnt}, mcnt);
    if (hold_chk) check("stable", {16'd0, out_data}, {16'd0, hold_val});
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    flush     = 1'b0;
    clr_cnt   = 1'b0;
    RST       = 1'b0;
  endtask

  initial begin
    mcnt = 0;
    idle();
    // Reset with an input beat offered
    RST = 1'b1; in_valid = 1'b1; in_data = 16'h00AA;
    step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, {16'd0, NOP});
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    RST = 1'b0; in_valid = 1'b0;
    step();
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_cnt", {30'd0, stall_cnt}, 32'd0);

    // Streaming at full rate
    rx.delete();
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      step();
      check("stream_data", {16'd0, out_data}, i);
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drained", {31'd0, out_valid}, 32'd0);
    check("stream_count", rx.size(), 32'd4);

    // Backpressure: 1 held, 2 in skid, 3 waits upstream
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    rx.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'd1; step();
    in_data = 16'd2; step();
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_cnt1", {30'd0, stall_cnt}, 32'd1);
    in_data = 16'd3; step();
    check("bp_head", {16'd0, out_data}, 32'd1);
    check("bp_cnt2", {30'd0, stall_cnt}, 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) in_valid = 1'b0;  // beat 3 accepted when in_ready returns
      step();
    end
    check("bp_rx_count", rx.size(), 32'd3);
    for (int i = 0; i < 3 && i < rx.size(); i++) check("bp_rx_order", {16'd0, rx[i]}, i + 1);

    // Flush while FULL with an input beat offered
    rx.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0011; step();
    in_data = 16'h0022; step();
    in_data = 16'h0033; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_out_data", {16'd0, out_data}, {16'd0, NOP});
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    step(); step();
    check("flush_no_leak", rx.size(), 32'd0);

    // Saturation at CW=2: 1,2,3,3,3 then clear during stall
    clr_cnt = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0077; step();
    clr_cnt = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("sat_cnt", {30'd0, stall_cnt}, (i < 3) ? i + 1 : 3);
    end
    step();
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    check("clr_cnt", {30'd0, stall_cnt}, 32'd0);
    flush = 1'b1; step(); flush = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 99) < 2);
      clr_cnt   = ($urandom_range(0, 99) < 3);
      RST       = ($urandom_range(0, 999) < 2);
      step();
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
